// File: rtl/cache_wb_unit_if.sv
// Memory write channel between the victim write-back engine and memory:
// a request beat carrying the line address, then a burst of data beats.
interface cache_wb_unit_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              wr_req_valid;
    logic              wr_req_ready;
    logic [ADDR_W-1:0] wr_req_addr;
    logic [7:0]        wr_req_len;
    logic              wr_data_valid;
    logic              wr_data_ready;
    logic [DATA_W-1:0] wr_data;
    logic              wr_data_last;

    modport master (
        output wr_req_valid, wr_req_addr, wr_req_len,
        output wr_data_valid, wr_data, wr_data_last,
        input  wr_req_ready, wr_data_ready
    );

    modport slave (
        input  wr_req_valid, wr_req_addr, wr_req_len,
        input  wr_data_valid, wr_data, wr_data_last,
        output wr_req_ready, wr_data_ready
    );
endinterface

// File: rtl/cache_wb_unit.sv
// Victim write-back engine: checks the victim set's dirty bit, bursts a dirty
// line to memory, then clears the bit. WB_PERF_CNT_EN adds the wb_cnt counter.
module cache_wb_unit #(
    parameter int LINE_WORDS = 8,
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int SET_W      = 3,
    parameter int TAG_W      = 24
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         evict_valid,
    output logic                         evict_ready,
    input  logic [SET_W-1:0]             evict_set,
    input  logic [TAG_W-1:0]             evict_tag,
    input  logic [LINE_WORDS*DATA_W-1:0] evict_data,
    output logic [SET_W-1:0]             dirty_raddr,
    input  logic                         dirty_rdata,
    output logic [SET_W-1:0]             dirty_waddr,
    output logic                         dirty_wdata,
    output logic                         dirty_wen,
    cache_wb_unit_if.master              mem,
    output logic                         wb_done,
    output logic                         wb_dirty
`ifdef WB_PERF_CNT_EN
    ,
    output logic [31:0]                  wb_cnt
`endif
);
    localparam int BEAT_W = $clog2(LINE_WORDS);
    localparam int OFF_W  = $clog2(LINE_WORDS * DATA_W / 8);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_REQ,
        S_DATA,
        S_CLEAR,
        S_DONE
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [BEAT_W-1:0] beat;
    logic [BEAT_W-1:0] beat_nxt;
    logic [SET_W-1:0]  set_r;
    logic [TAG_W-1:0]  tag_r;
    logic [DATA_W-1:0] words [LINE_WORDS];
    logic              dirty_r;
    logic              last;

    assign last = (beat == LAST_BEAT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            beat  <= '0;
        end else begin
            state <= state_nxt;
            beat  <= beat_nxt;
        end
    end

    // Victim line is latched at acceptance so the source is free immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            set_r   <= '0;
            tag_r   <= '0;
            dirty_r <= 1'b0;
            for (int unsigned i = 0; i < LINE_WORDS; i++) begin
                words[i] <= '0;
            end
        end else begin
            if (state == S_IDLE && evict_valid) begin
                set_r <= evict_set;
                tag_r <= evict_tag;
                for (int unsigned i = 0; i < LINE_WORDS; i++) begin
                    words[i] <= evict_data[i*DATA_W +: DATA_W];
                end
            end
            if (state == S_CHECK) begin
                dirty_r <= dirty_rdata;
            end
        end
    end

    always_comb begin
        state_nxt         = state;
        beat_nxt          = beat;
        evict_ready       = 1'b0;
        mem.wr_req_valid  = 1'b0;
        mem.wr_data_valid = 1'b0;
        dirty_wen         = 1'b0;
        wb_done           = 1'b0;
        wb_dirty          = 1'b0;
        case (state)
            S_IDLE: begin
                evict_ready = 1'b1;
                if (evict_valid) state_nxt = S_CHECK;
            end
            S_CHECK: begin
                state_nxt = dirty_rdata ? S_REQ : S_DONE;
            end
            S_REQ: begin
                mem.wr_req_valid = 1'b1;
                if (mem.wr_req_ready) begin
                    state_nxt = S_DATA;
                    beat_nxt  = '0;
                end
            end
            S_DATA: begin
                mem.wr_data_valid = 1'b1;
                if (mem.wr_data_ready) begin
                    if (last) begin
                        state_nxt = S_CLEAR;
                        beat_nxt  = '0;
                    end else begin
                        beat_nxt = beat + BEAT_W'(1);
                    end
                end
            end
            S_CLEAR: begin
                dirty_wen = 1'b1;
                state_nxt = S_DONE;
            end
            S_DONE: begin
                wb_done   = 1'b1;
                wb_dirty  = dirty_r;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign dirty_raddr      = set_r;
    assign dirty_waddr      = set_r;
    assign dirty_wdata      = 1'b0;
    assign mem.wr_req_addr  = {tag_r, set_r, {OFF_W{1'b0}}};
    assign mem.wr_req_len   = 8'(LINE_WORDS - 1);
    assign mem.wr_data      = words[beat];
    assign mem.wr_data_last = (state == S_DATA) && last;

`ifdef WB_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_cnt <= '0;
        end else if (state == S_CLEAR && wb_cnt != '1) begin
            wb_cnt <= wb_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_cache_wb_unit.sv
// Self-checking bench for cache_wb_unit: table vectors, hand-written corner
// sequences and a randomized phase against a line/dirty-bit reference model.
module tb_cache_wb_unit;
    localparam int LW = 8;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int SW = 3;
    localparam int TW = 24;

    logic              clk = 1'b0;
    logic              rst;
    logic              evict_valid;
    logic              evict_ready;
    logic [SW-1:0]     evict_set;
    logic [TW-1:0]     evict_tag;
    logic [LW*DW-1:0]  evict_data;
    logic [SW-1:0]     dirty_raddr;
    logic              dirty_rdata;
    logic [SW-1:0]     dirty_waddr;
    logic              dirty_wdata;
    logic              dirty_wen;
    logic              wb_done;
    logic              wb_dirty;
`ifdef WB_PERF_CNT_EN
    logic [31:0]       wb_cnt;
`endif

    cache_wb_unit_if #(.ADDR_W(AW), .DATA_W(DW)) mem ();

    cache_wb_unit #(
        .LINE_WORDS(LW), .DATA_W(DW), .ADDR_W(AW), .SET_W(SW), .TAG_W(TW)
    ) dut (
        .clk(clk), .rst(rst),
        .evict_valid(evict_valid), .evict_ready(evict_ready),
        .evict_set(evict_set), .evict_tag(evict_tag), .evict_data(evict_data),
        .dirty_raddr(dirty_raddr), .dirty_rdata(dirty_rdata),
        .dirty_waddr(dirty_waddr), .dirty_wdata(dirty_wdata), .dirty_wen(dirty_wen),
        .mem(mem.master),
        .wb_done(wb_done), .wb_dirty(wb_dirty)
`ifdef WB_PERF_CNT_EN
        , .wb_cnt(wb_cnt)
`endif
    );

    always #5 clk = ~clk;

    // External dirty array; the bench fills it through a write port of its own.
    logic          dirty_mem [1<<SW];
    logic          fill_en;
    logic [SW-1:0] fill_set;
    logic          fill_val;
    assign dirty_rdata = dirty_mem[dirty_raddr];
    always @(posedge clk) begin
        if (fill_en) dirty_mem[fill_set] <= fill_val;
        else if (dirty_wen) dirty_mem[dirty_waddr] <= dirty_wdata;
    end

    int          n_cmp = 0;
    int          n_bad = 0;
    logic        model_dirty [1<<SW];
    logic [31:0] cur_words [LW];
    int          exp_cnt = 0;

    typedef struct {
        logic [SW-1:0] set;
        logic [TW-1:0] tag;
        logic          dirty_in;
        int            stall;
        int            dmode;
        logic [31:0]   base;
        logic [31:0]   exp_addr;
        logic          exp_wb_dirty;
        int            exp_lat;
    } vec_t;
    vec_t vecs [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_evict_ready"}, 32'(evict_ready), 32'd1);
        check({tag, "_req_len"}, 32'(mem.wr_req_len), 32'd7);
        check({tag, "_req_valid"}, 32'(mem.wr_req_valid), 32'd0);
        check({tag, "_req_addr"}, mem.wr_req_addr, 32'd0);
        check({tag, "_data_valid"}, 32'(mem.wr_data_valid), 32'd0);
        check({tag, "_data"}, mem.wr_data, 32'd0);
        check({tag, "_data_last"}, 32'(mem.wr_data_last), 32'd0);
        check({tag, "_dirty_wen"}, 32'(dirty_wen), 32'd0);
        check({tag, "_dirty_raddr"}, 32'(dirty_raddr), 32'd0);
        check({tag, "_dirty_waddr"}, 32'(dirty_waddr), 32'd0);
        check({tag, "_wb_done"}, 32'(wb_done), 32'd0);
        check({tag, "_wb_dirty"}, 32'(wb_dirty), 32'd0);
`ifdef WB_PERF_CNT_EN
        check({tag, "_wb_cnt"}, wb_cnt, 32'd0);
`endif
    endtask

    task automatic set_dirty(input logic [SW-1:0] s, input logic v);
        fill_en  = 1'b1;
        fill_set = s;
        fill_val = v;
        model_dirty[s] = v;
        @(negedge clk);
        fill_en = 1'b0;
    endtask

    // dmode: 0 = data ready held high, 1 = toggling 1,0,1,0..., 2 = random readies.
    // abort_beat >= 0 asserts reset between edges right after that beat transfers.
    task automatic run_evict(input logic [SW-1:0] s, input logic [TW-1:0] t,
                             input int req_stall, input int dmode, input int abort_beat,
                             input logic exp_dirty, input logic [31:0] exp_addr,
                             input int exp_lat);
        int          k, guard, done_k, stall;
        bit          req_acc, req_pend, dat_pend, tog;
        logic [31:0] prev_addr, prev_data, got_addr;
        logic        prev_last, got_wbd, wen_data;
        logic [7:0]  got_len;
        logic [SW-1:0] wen_addr;
        int          n_req, n_wen, n_last, last_pos, stab_bad, early_bad, busy_bad;
        logic [31:0] beats [$];

        guard = 0;
        while (!evict_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("idle_before_evict", 32'(evict_ready), 32'd1);
        evict_valid = 1'b1;
        evict_set   = s;
        evict_tag   = t;
        for (int i = 0; i < LW; i++) evict_data[i*DW +: DW] = cur_words[i];
        mem.wr_req_ready  = 1'b0;
        mem.wr_data_ready = 1'b0;
        k = 0; done_k = -1; stall = req_stall;
        req_acc = 0; req_pend = 0; dat_pend = 0; tog = 1;
        prev_addr = '0; prev_data = '0; prev_last = 0; got_addr = '0; got_len = '0;
        got_wbd = 0; wen_addr = '0; wen_data = 0;
        n_req = 0; n_wen = 0; n_last = 0; last_pos = -1;
        stab_bad = 0; early_bad = 0; busy_bad = 0;
        while (done_k < 0 && k < 400) begin
            @(negedge clk);
            k++;
            evict_valid = 1'b0;
            if (evict_ready) busy_bad++;
            if (mem.wr_data_valid) begin
                if (!req_acc) early_bad++;
                if (dat_pend && (mem.wr_data !== prev_data || mem.wr_data_last !== prev_last))
                    stab_bad++;
                prev_data = mem.wr_data;
                prev_last = mem.wr_data_last;
                if (dmode == 0) mem.wr_data_ready = 1'b1;
                else if (dmode == 1) begin
                    mem.wr_data_ready = tog;
                    tog = !tog;
                end else mem.wr_data_ready = 1'($urandom_range(0, 1));
                dat_pend = !mem.wr_data_ready;
                if (mem.wr_data_ready) begin
                    beats.push_back(mem.wr_data);
                    if (mem.wr_data_last) begin
                        n_last++;
                        last_pos = beats.size() - 1;
                    end
                    if (abort_beat >= 0 && beats.size() == abort_beat + 1) begin
                        @(posedge clk);
                        #2 rst = 1'b0;
                        #1 check_reset_outputs("abort");
                        check("abort_no_wen", 32'(n_wen), 32'd0);
                        exp_cnt = 0;
                        mem.wr_req_ready  = 1'b0;
                        mem.wr_data_ready = 1'b0;
                        @(negedge clk);
                        rst = 1'b1;
                        @(negedge clk);
                        check("abort_ready_after", 32'(evict_ready), 32'd1);
                        check("abort_dirty_kept", 32'(dirty_mem[s]), 32'(model_dirty[s]));
                        return;
                    end
                end
            end else begin
                if (dat_pend) stab_bad++;
                dat_pend = 0;
                mem.wr_data_ready = 1'b0;
            end
            if (mem.wr_req_valid) begin
                if (req_pend && mem.wr_req_addr !== prev_addr) stab_bad++;
                prev_addr = mem.wr_req_addr;
                if (stall > 0) begin
                    stall--;
                    mem.wr_req_ready = 1'b0;
                end else mem.wr_req_ready = (dmode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
                req_pend = !mem.wr_req_ready;
                if (mem.wr_req_ready) begin
                    n_req++;
                    got_addr = mem.wr_req_addr;
                    got_len  = mem.wr_req_len;
                    req_acc  = 1;
                end
            end else begin
                if (req_pend) stab_bad++;
                req_pend = 0;
                mem.wr_req_ready = 1'b0;
            end
            if (dirty_wen) begin
                n_wen++;
                wen_addr = dirty_waddr;
                wen_data = dirty_wdata;
            end
            if (wb_done) begin
                done_k  = k;
                got_wbd = wb_dirty;
            end
        end
        mem.wr_req_ready  = 1'b0;
        mem.wr_data_ready = 1'b0;

        check("done_seen", 32'(done_k >= 0), 32'd1);
        if (exp_lat >= 0) check("clean_latency", 32'(done_k), 32'(exp_lat));
        check("wb_dirty", 32'(got_wbd), 32'(exp_dirty));
        check("req_count", 32'(n_req), 32'(exp_dirty));
        check("wen_count", 32'(n_wen), 32'(exp_dirty));
        check("beat_count", 32'(beats.size()), exp_dirty ? 32'(LW) : 32'd0);
        check("stability", 32'(stab_bad), 32'd0);
        check("early_data", 32'(early_bad), 32'd0);
        check("busy_ready", 32'(busy_bad), 32'd0);
        if (exp_dirty) begin
            check("req_addr", got_addr, exp_addr);
            check("req_len", 32'(got_len), 32'(LW - 1));
            check("last_count", 32'(n_last), 32'd1);
            check("last_pos", 32'(last_pos), 32'(LW - 1));
            check("wen_addr", 32'(wen_addr), 32'(s));
            check("wen_data", 32'(wen_data), 32'd0);
            for (int i = 0; i < LW && i < beats.size(); i++)
                check($sformatf("beat%0d", i), beats[i], cur_words[i]);
            model_dirty[s] = 1'b0;
            exp_cnt++;
        end
        @(negedge clk);
        check("dirty_bit_after", 32'(dirty_mem[s]), 32'(model_dirty[s]));
    endtask

    task automatic back_to_back();
        logic rdy [6];
        logic dn [6];
        logic [SW-1:0] raddr4;
        set_dirty(3'd1, 1'b0);
        set_dirty(3'd2, 1'b0);
        evict_valid = 1'b1;
        evict_set   = 3'd1;
        evict_tag   = 24'h55AA55;
        raddr4 = '0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            rdy[k] = evict_ready;
            dn[k]  = wb_done;
            if (k == 1) evict_set = 3'd2;
            if (k == 4) begin
                raddr4 = dirty_raddr;
                evict_valid = 1'b0;
            end
        end
        check("b2b_ready_k1", 32'(rdy[1]), 32'd0);
        check("b2b_done_k2", 32'(dn[2]), 32'd1);
        check("b2b_ready_k2", 32'(rdy[2]), 32'd0);
        check("b2b_ready_k3", 32'(rdy[3]), 32'd1);
        check("b2b_ready_k4", 32'(rdy[4]), 32'd0);
        check("b2b_raddr_k4", 32'(raddr4), 32'd2);
        check("b2b_done_k5", 32'(dn[5]), 32'd1);
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [SW-1:0] s;
        logic [TW-1:0] t;
        logic          d;

        vecs[0] = '{3'd3, 24'h123456, 1'b0, 0, 0, 32'h0,        32'h12345660, 1'b0, 2};
        vecs[1] = '{3'd5, 24'hABCDEF, 1'b1, 0, 0, 32'h100,      32'hABCDEFA0, 1'b1, -1};
        vecs[2] = '{3'd5, 24'hABCDEF, 1'b1, 4, 1, 32'h100,      32'hABCDEFA0, 1'b1, -1};
        vecs[3] = '{3'd0, 24'hFFFFFF, 1'b1, 0, 0, 32'hFFFFFFF8, 32'hFFFFFF00, 1'b1, -1};
        vecs[4] = '{3'd7, 24'h000000, 1'b1, 2, 2, 32'h0,        32'h000000E0, 1'b1, -1};

        rst = 1'b0;
        evict_valid = 1'b0; evict_set = '0; evict_tag = '0; evict_data = '0;
        mem.wr_req_ready = 1'b0; mem.wr_data_ready = 1'b0;
        fill_en = 1'b0; fill_set = '0; fill_val = 1'b0;
        #12 check_reset_outputs("reset");
        @(negedge clk);
        for (int i = 0; i < (1 << SW); i++) set_dirty(SW'(i), 1'b0);
        rst = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 5; v++) begin
            for (int i = 0; i < LW; i++) cur_words[i] = vecs[v].base + 32'(i);
            set_dirty(vecs[v].set, vecs[v].dirty_in);
            run_evict(vecs[v].set, vecs[v].tag, vecs[v].stall, vecs[v].dmode, -1,
                      vecs[v].exp_wb_dirty, vecs[v].exp_addr, vecs[v].exp_lat);
        end

        back_to_back();

        for (int i = 0; i < LW; i++) cur_words[i] = 32'h200 + 32'(i);
        set_dirty(3'd6, 1'b1);
        run_evict(3'd6, 24'h0F0F0F, 0, 0, 3, 1'b1, 32'h0F0F0FC0, -1);

        for (int e = 0; e < 5; e++) begin
            d = (e < 3);
            s = SW'(e);
            t = TW'($urandom);
            for (int i = 0; i < LW; i++) cur_words[i] = $urandom;
            set_dirty(s, d);
            run_evict(s, t, 0, 0, -1, d, 32'(t) * 256 + 32'(s) * 32, d ? -1 : 2);
        end
`ifdef WB_PERF_CNT_EN
        check("wb_cnt_three", wb_cnt, 32'd3);
`endif

        for (int e = 0; e < 40; e++) begin
            s = SW'($urandom_range(0, 7));
            t = TW'($urandom);
            for (int i = 0; i < LW; i++) cur_words[i] = $urandom;
            set_dirty(SW'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
            set_dirty(s, 1'($urandom_range(0, 1)));
            d = model_dirty[s];
            run_evict(s, t, $urandom_range(0, 3), 2, -1, d,
                      32'(t) * 256 + 32'(s) * 32, d ? -1 : 2);
        end
`ifdef WB_PERF_CNT_EN
        check("wb_cnt_final", wb_cnt, 32'(exp_cnt));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
